// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter sharing one sd_card_reader byte port; one read in flight, 3-cycle min request-to-ack.
// No backpressure: requests wait in IDLE until the reader is ready; an unanswered read becomes an err pulse.
module sd_read_arbiter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] ack_o,
  output logic [1:0] err_o,
  output logic [7:0] data_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       sd_read_data_o,
  input  logic [7:0] sd_data_i,
  input  logic       sd_valid_i,
  input  logic       sd_ready_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ack_d, err_d, grant_d;
  logic [7:0]    data_d;
  logic          busy_d, rd_d;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    data_d  = data_o;
    grant_d = grant_o;
    busy_d  = busy_o;
    rd_d    = 1'b0;
    // Port 1 wins alone, or on a tie when port 0 was served last.
    win     = (req_i == 2'b10) || ((req_i == 2'b11) && !last_q);
    case (state_q)
      IDLE: begin
        if (sd_ready_i && (req_i != 2'b00)) begin
          grant_d = win ? 2'b10 : 2'b01;
          last_d  = win;
          busy_d  = 1'b1;
          rd_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (sd_valid_i) begin
          data_d  = sd_data_i;
          ack_d   = grant_o;
          state_d = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = grant_o;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        grant_d = 2'b00;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      cnt_q          <= '0;
      ack_o          <= 2'b00;
      err_o          <= 2'b00;
      data_o         <= 8'h00;
      grant_o        <= 2'b00;
      busy_o         <= 1'b0;
      sd_read_data_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      ack_o          <= ack_d;
      err_o          <= err_d;
      data_o         <= data_d;
      grant_o        <= grant_d;
      busy_o         <= busy_d;
      sd_read_data_o <= rd_d;
    end
  end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Directed bench for sd_read_arbiter: scoreboard of expected ack/err/data, immediate-assertion checks.
module tb_sd_read_arbiter;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] ack_o, err_o, grant_o;
  logic [7:0] data_o;
  logic       busy_o, sd_read_data_o;
  logic [7:0] sd_data;
  logic       sd_valid, sd_ready;

  typedef struct packed {
    logic [1:0] ack;
    logic [1:0] err;
    logic [7:0] data;
  } resp_t;

  resp_t      sb[$];
  int         errors = 0;
  int         checks = 0;
  int         issue_cnt = 0;
  int         overlap_cnt = 0;
  int         exp_issues = 0;
  logic       mlast;
  logic [7:0] exp_data;

  sd_read_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req),
    .ack_o          (ack_o),
    .err_o          (err_o),
    .data_o         (data_o),
    .grant_o        (grant_o),
    .busy_o         (busy_o),
    .sd_read_data_o (sd_read_data_o),
    .sd_data_i      (sd_data),
    .sd_valid_i     (sd_valid),
    .sd_ready_i     (sd_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sd_read_data_o === 1'b1) issue_cnt++;
    if ((ack_o != 2'b00) && (err_o != 2'b00)) overlap_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pick(input logic [1:0] r, input logic l);
    if (r == 2'b01) return 2'b01;
    if (r == 2'b10) return 2'b10;
    return l ? 2'b01 : 2'b10;
  endfunction

  task automatic wait_issue(output logic [1:0] eg);
    int n = 0;
    eg = pick(req, mlast);
    while (sd_read_data_o !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("issue_seen", sd_read_data_o, 1);
    chk("grant", grant_o, eg);
    chk("busy", busy_o, 1);
    mlast = eg[1];
    exp_issues++;
  endtask

  task automatic pulse_valid(input logic [7:0] d);
    sd_valid = 1'b1;
    sd_data  = d;
    tick;
    sd_valid = 1'b0;
  endtask

  task automatic wait_resp(input int budget, output int n);
    resp_t e;
    n = 0;
    while ((ack_o | err_o) == 2'b00 && n < budget) begin
      tick;
      n++;
    end
    chk("resp_seen", ((ack_o | err_o) != 2'b00), 1);
    chk("sb_nonempty", (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("ack", ack_o, e.ack);
      chk("err", err_o, e.err);
      chk("data", data_o, e.data);
    end
  endtask

  task automatic serve(input logic [7:0] d, input int gap, input bit drop);
    logic [1:0] eg;
    resp_t      e;
    int         n;
    wait_issue(eg);
    tick;
    chk("issue_one_cycle", sd_read_data_o, 0);
    repeat (gap - 1) tick;
    if (drop) req = 2'b00;
    e.ack = eg;
    e.err = 2'b00;
    e.data = d;
    sb.push_back(e);
    exp_data = d;
    pulse_valid(d);
    wait_resp(T + 4, n);
    chk("ack_latency", n, 0);
    chk("grant_in_release", grant_o, eg);
  endtask

  initial begin
    logic [1:0] eg;
    resp_t      e;
    int         n;
    int         bad;

    rst = 1'b1; req = 2'b00; sd_valid = 1'b0; sd_data = 8'h00; sd_ready = 1'b0;
    tick;
    tick;
    chk("rst_ack", ack_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_rd", sd_read_data_o, 0);
    chk("rst_busy", busy_o, 0);
    rst = 1'b0; mlast = 1'b1; exp_data = 8'h00;

    // Reader not ready: request must be held off.
    req = 2'b01;
    bad = 0;
    repeat (50) begin
      tick;
      if (sd_read_data_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    chk("notready_activity", bad, 0);
    chk("notready_issues", issue_cnt, 0);
    sd_ready = 1'b1;
    tick;
    chk("issue_after_ready", sd_read_data_o, 1);
    serve(8'hA5, 2, 1);
    tick;
    chk("idle_grant", grant_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_ack", ack_o, 0);
    chk("single_issue_count", issue_cnt, 1);

    // Fresh reset, then continuous tie: 01,10,01,10.
    rst = 1'b1; req = 2'b00;
    tick;
    tick;
    rst = 1'b0; mlast = 1'b1; exp_data = 8'h00;
    req = 2'b11;
    for (int i = 0; i < 4; i++) serve(8'h30 + 8'(i), 1, 0);
    req = 2'b10;
    for (int i = 0; i < 3; i++) serve(8'h50 + 8'(i), 1, 0);

    // Timeout with no reader answer.
    req = 2'b01;
    wait_issue(eg);
    req = 2'b00;
    e.ack = 2'b00; e.err = eg; e.data = exp_data;
    sb.push_back(e);
    wait_resp(T + 6, n);
    chk("timeout_cycles", n, T + 1);

    // Valid on the last WAIT cycle wins over the timeout.
    req = 2'b01;
    serve(8'hC3, T, 1);

    // Stray valid while idle.
    tick;
    tick;
    chk("stray_pre_busy", busy_o, 0);
    pulse_valid(8'hEE);
    bad = 0;
    repeat (3) begin
      if ((ack_o | err_o) != 2'b00 || busy_o !== 1'b0) bad++;
      tick;
    end
    chk("stray_activity", bad, 0);
    chk("stray_data", data_o, exp_data);

    // Requester drops its request during WAIT.
    req = 2'b10;
    serve(8'h77, 1, 1);

    // Reset during WAIT.
    tick;
    req = 2'b01;
    wait_issue(eg);
    tick;
    rst = 1'b1;
    tick;
    chk("midrst_ack", ack_o, 0);
    chk("midrst_err", err_o, 0);
    chk("midrst_grant", grant_o, 0);
    chk("midrst_data", data_o, 0);
    chk("midrst_rd", sd_read_data_o, 0);
    chk("midrst_busy", busy_o, 0);
    rst = 1'b0; req = 2'b00; mlast = 1'b1; exp_data = 8'h00;
    bad = 0;
    repeat (T + 6) begin
      tick;
      if ((ack_o | err_o) != 2'b00) bad++;
    end
    chk("no_resp_after_rst", bad, 0);

    chk("sb_empty", sb.size(), 0);
    chk("issue_count", issue_cnt, exp_issues);
    chk("ack_err_overlap", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_read_arbiter.md
# sd_read_arbiter

Shares the single byte-read port of `sd_card_reader` between two requesters: audio streaming on port 0 and a general loader on port 1. The block sequences one outstanding read at a time and alternates round-robin between the two ports when both are requesting. It returns each byte with a one-cycle acknowledge and converts a reader that never answers into a per-port error pulse. It sits between the requesters and `sd_card_reader` and drives the reader's `read_data` pulse.

## Interface
- `TIMEOUT_CYCLES`, default 100000: WAIT cycles allowed before a read is abandoned (1 ms at 100 MHz); minimum 2.
- `clk` in 1: system clock (100 MHz PLL output).
- `rst` in 1: synchronous, active-high reset.
- `req_i` in 2: per-port read request, level; bit 0 = audio, bit 1 = loader.
- `ack_o` out 2: one-cycle pulse to the served port; `data_o` is valid in the same cycle.
- `err_o` out 2: one-cycle pulse to the served port on timeout, issued instead of `ack_o`.
- `data_o` out 8: returned byte; holds its value between acks.
- `grant_o` out 2: one-hot owner of the transaction in flight; 0 when IDLE.
- `busy_o` out 1: high in every state except IDLE.
- `sd_read_data_o` out 1: one-cycle read trigger to `sd_card_reader.read_data`.
- `sd_data_i` in 8: byte from the reader.
- `sd_valid_i` in 1: reader pulse; `sd_data_i` is valid in that cycle.
- `sd_ready_i` in 1: reader is initialised and idle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RELEASE. All outputs are registered.
- **IDLE**
  - Leaves IDLE when `sd_ready_i` is high and `req_i` is nonzero.
  - Grant rule:
    - Single requester: that requester wins.
    - Both requesting: the port other than `last` wins.
  - On grant: `grant_o` gets the one-hot winner, `last` is updated, and the FSM moves to ISSUE.
  - With `sd_ready_i` low, IDLE holds regardless of `req_i`.
- **ISSUE** (exactly one cycle)
  - `sd_read_data_o` = 1.
  - Timeout counter cleared to 0.
  - Next state: WAIT.
- **WAIT**
  - On `sd_valid_i`: capture `sd_data_i` into `data_o`, set `ack_o[g]`, go to RELEASE.
  - Else if counter == `TIMEOUT_CYCLES`-1: set `err_o[g]`, leave `data_o` unchanged, go to RELEASE.
  - Else: increment the counter.
  - If `sd_valid_i` and the timeout condition occur in the same cycle, valid wins.
- **RELEASE** (exactly one cycle)
  - `ack_o` or `err_o` is high for the granted port.
  - Clears `grant_o`; next state is IDLE.
- `sd_valid_i` is ignored outside WAIT.
- `req_i` is sampled only in IDLE.
  - A requester dropping `req_i` mid-transaction does not abort it; the ack/err is still pulsed.
  - A requester that clears its request on seeing `ack_o` is not re-served; one that keeps it high is served again. This allows back-to-back streaming.
- Counter width is `$clog2(TIMEOUT_CYCLES)`. The counter never wraps because it stops at the compare value.
- **Reset**
  - State IDLE, `last` = 1 (port 0 wins the first tie).
  - `ack_o`, `err_o`, `grant_o`, `data_o`, `sd_read_data_o`, `busy_o` and the counter are all 0.
  - Reset asserted mid-transaction returns the block to IDLE on the next edge with no ack or err.
  - The reader shares `rst`, so no orphaned read survives.

## Timing
- Request high at edge 0 in IDLE with `sd_ready_i` high:
  - `grant_o` and `busy_o` set, state ISSUE, `sd_read_data_o` high in cycle 1.
  - WAIT from cycle 2.
- `sd_valid_i` seen at cycle k ≥ 2: `ack_o` and `data_o` in cycle k+1, IDLE in cycle k+2.
- Minimum request-to-ack latency is 3 cycles. Minimum issue-to-issue spacing for back-to-back reads is 4 cycles.
- Timeout with no `sd_valid_i`: `err_o` in cycle `TIMEOUT_CYCLES`+2.
- Exactly one `sd_read_data_o` pulse per grant. `ack_o` and `err_o` are never high together.

## Test plan
- Single read: `req_i`=01, `sd_valid_i` with 0xA5 two cycles after the issue pulse → `ack_o`=01 with `data_o`=0xA5 in one cycle; exactly one `sd_read_data_o` pulse; `grant_o` 01 then 00.
- Tie and round-robin: `req_i`=11 held continuously and the reader answers every read → grants follow 01, 10, 01, 10. With only port 1 requesting, it is granted repeatedly.
- Reader not ready: `req_i`=01 with `sd_ready_i`=0 for 50 cycles → no issue pulse and `busy_o`=0. `sd_ready_i` rises → issue pulse 1 cycle later.
- Timeout: `TIMEOUT_CYCLES`=8, no `sd_valid_i` → `err_o`=01 in cycle 10, `ack_o` stays 0, `data_o` unchanged. A valid arriving on the last WAIT cycle yields an ack, not an err.
- Robustness:
  - Stray `sd_valid_i` in IDLE is ignored.
  - Dropping `req_i` in WAIT still produces the ack.
  - `rst` pulsed during WAIT → all outputs 0 next cycle and no ack afterwards.
  - The first tie after reset goes to port 0.
